// File: rtl/mig_app_responder.sv
// mig_app_responder: behavioural stand-in for the MIG 7-series app_* interface.
// Emulates calibration delay, command / write-data handshakes, in-order
// execution against a small internal memory and fixed-latency read return.
// Optional feature macro: MIG_RESP_BACKPRESSURE_EN (periodic forced app_rdy=0).
//
// Handshake rule used on every channel here: an item transfers on a rising
// ui_clk edge where its valid (app_en / app_wdf_wren) and its ready
// (app_rdy / app_wdf_rdy) are both high; ready never depends on valid, and an
// item offered while ready is low is simply not taken.
module mig_app_responder #(
  parameter int ADDR_WIDTH      = 29,
  parameter int DATA_WIDTH      = 256,
  parameter int MASK_WIDTH      = 32,
  parameter int MEM_WORDS_LOG2  = 6,
  parameter int CALIB_CYCLES    = 16,
  parameter int RD_LATENCY      = 4,
  parameter int FIFO_DEPTH_LOG2 = 2,
  parameter int STALL_PERIOD    = 64
) (
  input  logic                  ui_clk,
  input  logic                  ui_clk_sync_rst,
  input  logic [ADDR_WIDTH-1:0] app_addr,
  input  logic [2:0]            app_cmd,
  input  logic                  app_en,
  output logic                  app_rdy,
  input  logic [DATA_WIDTH-1:0] app_wdf_data,
  input  logic [MASK_WIDTH-1:0] app_wdf_mask,
  input  logic                  app_wdf_wren,
  input  logic                  app_wdf_end,
  output logic                  app_wdf_rdy,
  output logic [DATA_WIDTH-1:0] app_rd_data,
  output logic                  app_rd_data_valid,
  output logic                  app_rd_data_end,
  input  logic                  app_ref_req,
  input  logic                  app_zq_req,
  output logic                  app_ref_ack,
  output logic                  app_zq_ack,
  output logic                  app_sr_active,
  output logic                  init_calib_complete,
  output logic                  protocol_err
);

  localparam int DEPTH = 1 << FIFO_DEPTH_LOG2;
  localparam int PW    = FIFO_DEPTH_LOG2;
  localparam int CNTW  = FIFO_DEPTH_LOG2 + 1;
  localparam int WORDS = 1 << MEM_WORDS_LOG2;
  localparam int CW    = $clog2(CALIB_CYCLES + 1);
  localparam int MW    = MEM_WORDS_LOG2;

  logic          calib;
  logic [CW-1:0] calib_cnt;
  logic          stall;

  // Command FIFO entry: {is_read, word index}
  logic [MW:0]   cmd_mem [DEPTH];
  logic [PW-1:0] cmd_wp, cmd_rp;
  logic [CNTW-1:0] cmd_cnt;
  logic          cmd_full, cmd_empty, cmd_accept, cmd_legal, cmd_push, cmd_pop;

  logic [DATA_WIDTH-1:0] wdf_data [DEPTH];
  logic [MASK_WIDTH-1:0] wdf_mask [DEPTH];
  logic [PW-1:0]   wdf_wp, wdf_rp;
  logic [CNTW-1:0] wdf_cnt;
  logic            wdf_full, wdf_empty, wdf_push, wdf_pop;

  logic          head_rd;
  logic [MW-1:0] head_word;
  logic          exec_wr, exec_rd;

  logic [DATA_WIDTH-1:0] mem [WORDS];
  logic [RD_LATENCY-1:0] pipe_vld;
  logic [DATA_WIDTH-1:0] pipe_data [RD_LATENCY];

  // Address bits outside the word index are intentionally ignored (aliasing).
  logic unused_addr_bits;
  assign unused_addr_bits = ^{app_addr[ADDR_WIDTH-1:MW+3], app_addr[2:0]};

  // Calibration counter: runs from reset release, then latches done.
  always_ff @(posedge ui_clk or posedge ui_clk_sync_rst) begin
    if (ui_clk_sync_rst) begin
      calib_cnt <= '0;
      calib     <= 1'b0;
    end else if (!calib) begin
      calib_cnt <= calib_cnt + CW'(1);
      if (calib_cnt == CW'(CALIB_CYCLES - 1)) calib <= 1'b1;
    end
  end

`ifdef MIG_RESP_BACKPRESSURE_EN
  localparam int SW = $clog2(STALL_PERIOD);
  logic [SW-1:0] stall_cnt;

  // Free-running refresh emulation counter; last 4 counts block commands.
  always_ff @(posedge ui_clk or posedge ui_clk_sync_rst) begin
    if (ui_clk_sync_rst) stall_cnt <= '0;
    else if (stall_cnt == SW'(STALL_PERIOD - 1)) stall_cnt <= '0;
    else stall_cnt <= stall_cnt + SW'(1);
  end
  assign stall = (stall_cnt >= SW'(STALL_PERIOD - 4));
`else
  // No forced stalls; expression is constant 0 for any legal period.
  assign stall = (STALL_PERIOD < 0);
`endif

  assign cmd_full   = (cmd_cnt == CNTW'(DEPTH));
  assign cmd_empty  = (cmd_cnt == '0);
  assign wdf_full   = (wdf_cnt == CNTW'(DEPTH));
  assign wdf_empty  = (wdf_cnt == '0);

  assign app_rdy     = calib & ~cmd_full & ~stall;
  assign app_wdf_rdy = calib & ~wdf_full;

  assign cmd_accept = app_en & app_rdy;
  assign cmd_legal  = (app_cmd == 3'b000) || (app_cmd == 3'b001);
  assign cmd_push   = cmd_accept & cmd_legal;
  assign wdf_push   = app_wdf_wren & app_wdf_rdy;

  // Execute at the FIFO head: writes wait for their data beat, reads go.
  assign head_rd   = cmd_mem[cmd_rp][MW];
  assign head_word = cmd_mem[cmd_rp][MW-1:0];
  assign exec_wr   = ~cmd_empty & ~head_rd & ~wdf_empty;
  assign exec_rd   = ~cmd_empty & head_rd;
  assign cmd_pop   = exec_wr | exec_rd;
  assign wdf_pop   = exec_wr;

  // FIFO storage; contents need no reset since pointers qualify them.
  always_ff @(posedge ui_clk) begin
    if (cmd_push) cmd_mem[cmd_wp] <= {app_cmd[0], app_addr[MW+2:3]};
    if (wdf_push) begin
      wdf_data[wdf_wp] <= app_wdf_data;
      wdf_mask[wdf_wp] <= app_wdf_mask;
    end
  end

  // FIFO pointers and occupancy counts.
  always_ff @(posedge ui_clk or posedge ui_clk_sync_rst) begin
    if (ui_clk_sync_rst) begin
      cmd_wp  <= '0;
      cmd_rp  <= '0;
      cmd_cnt <= '0;
      wdf_wp  <= '0;
      wdf_rp  <= '0;
      wdf_cnt <= '0;
    end else begin
      if (cmd_push) cmd_wp <= cmd_wp + PW'(1);
      if (cmd_pop)  cmd_rp <= cmd_rp + PW'(1);
      cmd_cnt <= cmd_cnt + CNTW'(cmd_push) - CNTW'(cmd_pop);
      if (wdf_push) wdf_wp <= wdf_wp + PW'(1);
      if (wdf_pop)  wdf_rp <= wdf_rp + PW'(1);
      wdf_cnt <= wdf_cnt + CNTW'(wdf_push) - CNTW'(wdf_pop);
    end
  end

  // Memory array: byte-masked writes, survives reset.
  always_ff @(posedge ui_clk) begin
    if (exec_wr) begin
      for (int b = 0; b < MASK_WIDTH; b++) begin
        if (!wdf_mask[wdf_rp][b]) mem[head_word][b*8 +: 8] <= wdf_data[wdf_rp][b*8 +: 8];
      end
    end
  end

  // Read pipeline valid bits; cleared by reset so in-flight reads vanish.
  always_ff @(posedge ui_clk or posedge ui_clk_sync_rst) begin
    if (ui_clk_sync_rst) begin
      pipe_vld <= '0;
    end else begin
      pipe_vld[0] <= exec_rd;
      for (int i = 1; i < RD_LATENCY; i++) pipe_vld[i] <= pipe_vld[i-1];
    end
  end

  // Read pipeline data, qualified by pipe_vld.
  always_ff @(posedge ui_clk) begin
    pipe_data[0] <= mem[head_word];
    for (int i = 1; i < RD_LATENCY; i++) pipe_data[i] <= pipe_data[i-1];
  end

  // Read return register; data holds its last value between beats.
  always_ff @(posedge ui_clk or posedge ui_clk_sync_rst) begin
    if (ui_clk_sync_rst) begin
      app_rd_data_valid <= 1'b0;
      app_rd_data       <= '0;
    end else begin
      app_rd_data_valid <= pipe_vld[RD_LATENCY-1];
      if (pipe_vld[RD_LATENCY-1]) app_rd_data <= pipe_data[RD_LATENCY-1];
    end
  end

  // Maintenance acks (one cycle after request) and sticky protocol flag.
  always_ff @(posedge ui_clk or posedge ui_clk_sync_rst) begin
    if (ui_clk_sync_rst) begin
      app_ref_ack  <= 1'b0;
      app_zq_ack   <= 1'b0;
      protocol_err <= 1'b0;
    end else begin
      app_ref_ack <= app_ref_req;
      app_zq_ack  <= app_zq_req;
      if ((app_wdf_wren & ~app_wdf_rdy) ||
          (app_wdf_end != app_wdf_wren) ||
          (cmd_accept & ~cmd_legal) ||
          ((app_en | app_wdf_wren) & ~calib))
        protocol_err <= 1'b1;
    end
  end

  assign app_rd_data_end     = app_rd_data_valid;
  assign app_sr_active       = 1'b0;
  assign init_calib_complete = calib;

endmodule

// File: tb/tb_mig_app_responder.sv
// tb_mig_app_responder: directed bench for mig_app_responder (default build).
module tb_mig_app_responder;

  localparam int RD_LAT = 4;

  logic         ui_clk = 1'b0;
  logic         ui_clk_sync_rst = 1'b1;
  logic [28:0]  app_addr = '0;
  logic [2:0]   app_cmd = '0;
  logic         app_en = 1'b0;
  logic         app_rdy;
  logic [255:0] app_wdf_data = '0;
  logic [31:0]  app_wdf_mask = '0;
  logic         app_wdf_wren = 1'b0;
  logic         app_wdf_end = 1'b0;
  logic         app_wdf_rdy;
  logic [255:0] app_rd_data;
  logic         app_rd_data_valid;
  logic         app_rd_data_end;
  logic         app_ref_req = 1'b0;
  logic         app_zq_req = 1'b0;
  logic         app_ref_ack;
  logic         app_zq_ack;
  logic         app_sr_active;
  logic         init_calib_complete;
  logic         protocol_err;

  mig_app_responder dut (
    .ui_clk(ui_clk), .ui_clk_sync_rst(ui_clk_sync_rst),
    .app_addr(app_addr), .app_cmd(app_cmd), .app_en(app_en), .app_rdy(app_rdy),
    .app_wdf_data(app_wdf_data), .app_wdf_mask(app_wdf_mask),
    .app_wdf_wren(app_wdf_wren), .app_wdf_end(app_wdf_end), .app_wdf_rdy(app_wdf_rdy),
    .app_rd_data(app_rd_data), .app_rd_data_valid(app_rd_data_valid),
    .app_rd_data_end(app_rd_data_end),
    .app_ref_req(app_ref_req), .app_zq_req(app_zq_req),
    .app_ref_ack(app_ref_ack), .app_zq_ack(app_zq_ack),
    .app_sr_active(app_sr_active), .init_calib_complete(init_calib_complete),
    .protocol_err(protocol_err)
  );

  // clock / cycle counter
  always #5 ui_clk = ~ui_clk;
  int cyc = 0;
  always @(posedge ui_clk) cyc <= cyc + 1;

  // scoreboard state
  logic [255:0] exp_q[$];
  int n_cmp = 0;
  int n_err = 0;
  int n_rd_got = 0;
  int acc_cyc = 0;
  int first_valid_cyc = 0;
  int last_valid_cyc = 0;
  bit first_pending = 1'b0;

  task automatic check(input string tag, input logic [255:0] got, input logic [255:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge ui_clk); #1;
  endtask

  task automatic send_cmd(input logic [2:0] cmd, input logic [28:0] addr);
    int t = 0;
    app_cmd = cmd; app_addr = addr; app_en = 1'b1;
    while (!app_rdy && t < 200) begin tick(); t++; end
    check("cmd_rdy", app_rdy, 1);
    tick();
    acc_cyc = cyc;
    app_en = 1'b0;
  endtask

  task automatic send_beat(input logic [255:0] data, input logic [31:0] mask);
    int t = 0;
    app_wdf_data = data; app_wdf_mask = mask; app_wdf_wren = 1'b1; app_wdf_end = 1'b1;
    while (!app_wdf_rdy && t < 200) begin tick(); t++; end
    check("wdf_rdy", app_wdf_rdy, 1);
    tick();
    app_wdf_wren = 1'b0; app_wdf_end = 1'b0;
  endtask

  task automatic send_wr(input logic [28:0] addr, input logic [255:0] data, input logic [31:0] mask);
    int t = 0;
    app_cmd = 3'b000; app_addr = addr; app_en = 1'b1;
    app_wdf_data = data; app_wdf_mask = mask; app_wdf_wren = 1'b1; app_wdf_end = 1'b1;
    while (!(app_rdy && app_wdf_rdy) && t < 200) begin tick(); t++; end
    check("wr_rdy", app_rdy && app_wdf_rdy, 1);
    tick();
    app_en = 1'b0; app_wdf_wren = 1'b0; app_wdf_end = 1'b0;
  endtask

  task automatic send_rd(input logic [28:0] addr, input logic [255:0] exp);
    exp_q.push_back(exp);
    send_cmd(3'b001, addr);
  endtask

  task automatic wait_drain();
    int t = 0;
    while (exp_q.size() != 0 && t < 100) begin tick(); t++; end
    check("drain", exp_q.size(), 0);
  endtask

  task automatic wait_calib();
    int t = 0;
    while (!init_calib_complete && t < 40) begin tick(); t++; end
    check("calib_done", init_calib_complete, 1);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_rdy"}, {app_rdy, app_wdf_rdy}, 0);
    check({tag, "_calib"}, init_calib_complete, 0);
    check({tag, "_valid"}, {app_rd_data_valid, app_rd_data_end}, 0);
    check({tag, "_data"}, app_rd_data, 0);
    check({tag, "_misc"}, {app_ref_ack, app_zq_ack, app_sr_active, protocol_err}, 0);
  endtask

  initial begin
    logic [255:0] v;
    int snap;

    // read-return monitor, sampled on the falling edge
    fork
      forever begin
        @(negedge ui_clk);
        if (app_rd_data_valid) begin
          n_rd_got++;
          last_valid_cyc = cyc;
          if (first_pending) begin first_valid_cyc = cyc; first_pending = 1'b0; end
          check("rd_end", app_rd_data_end, 1);
          if (exp_q.size() == 0) check("rd_unexpected", app_rd_data_valid, 0);
          else check("rd_data", app_rd_data, exp_q.pop_front());
        end
      end
    join_none

    // 1: reset values and calibration timing
    repeat (3) tick();
    check_reset_outputs("rst");
    ui_clk_sync_rst = 1'b0;
    check("calib_c0", {init_calib_complete, app_rdy}, 0);
    for (int i = 1; i <= 16; i++) begin
      tick();
      check($sformatf("calib_c%0d", i), {init_calib_complete, app_rdy, app_wdf_rdy},
            (i >= 16) ? 3'b111 : 3'b000);
    end

    // 2: ten writes then ten back-to-back reads
    for (int i = 0; i < 10; i++) send_wr(29'(i * 8), 256'(i * 2 + 2), 32'h0);
    first_pending = 1'b1;
    snap = n_rd_got;
    send_rd(29'd0, 256'd2);
    v = 256'(acc_cyc);
    for (int i = 1; i < 10; i++) send_rd(29'(i * 8), 256'(i * 2 + 2));
    wait_drain();
    check("t2_beats", n_rd_got - snap, 10);
    check("t2_latency", first_valid_cyc - int'(v), RD_LAT + 1);
    check("t2_b2b", last_valid_cyc - first_valid_cyc, 9);
    check("t2_perr", protocol_err, 0);

    // maintenance acks
    app_ref_req = 1'b1; app_zq_req = 1'b1;
    check("ack_same", {app_ref_ack, app_zq_ack}, 0);
    tick();
    app_ref_req = 1'b0; app_zq_req = 1'b0;
    check("ack_next", {app_ref_ack, app_zq_ack, app_sr_active}, 3'b110);
    tick();
    check("ack_drop", {app_ref_ack, app_zq_ack}, 0);

    // 3: data ahead of command, byte mask, aliasing
    send_wr(29'd16, 256'd0, 32'h0);
    send_beat({8{32'hAAAA_AAAA}}, 32'hFFFF_FFF0);
    tick();
    send_cmd(3'b000, 29'd16);
    send_rd(29'd16, 256'hAAAA_AAAA);
    send_rd(29'd528, 256'hAAAA_AAAA);
    wait_drain();

    // 4: command FIFO fills while writes wait for data
    for (int k = 0; k < 4; k++) send_cmd(3'b000, 29'(160 + k * 8));
    check("t4_full", app_rdy, 0);
    app_cmd = 3'b000; app_addr = 29'd192; app_en = 1'b1;
    tick();
    app_en = 1'b0;
    check("t4_still_full", app_rdy, 0);
    for (int k = 0; k < 4; k++) send_beat(256'(32'h100 + k), 32'h0);
    tick(); tick();
    check("t4_drained", {app_rdy, app_wdf_rdy}, 2'b11);
    for (int k = 0; k < 4; k++) send_rd(29'(160 + k * 8), 256'(32'h100 + k));
    wait_drain();
    check("t4_perr", protocol_err, 0);

    // 5: reset with reads in flight
    for (int k = 0; k < 3; k++) send_cmd(3'b001, 29'd0);
    ui_clk_sync_rst = 1'b1;
    snap = n_rd_got;
    repeat (3) tick();
    check_reset_outputs("midrst");
    ui_clk_sync_rst = 1'b0;
    wait_calib();
    repeat (10) tick();
    check("t5_no_valid", n_rd_got - snap, 0);
    send_rd(29'd0, 256'd2);
    wait_drain();

    // 6: protocol violations are sticky
    send_cmd(3'b010, 29'd0);
    check("t6_badcmd", protocol_err, 1);
    repeat (3) tick();
    check("t6_badcmd_sticky", protocol_err, 1);
    ui_clk_sync_rst = 1'b1;
    tick();
    ui_clk_sync_rst = 1'b0;
    check("t6_rst_clear", protocol_err, 0);
    wait_calib();
    for (int k = 0; k < 4; k++) send_beat(256'(k), 32'h0);
    check("t6_wdf_full", {app_wdf_rdy, protocol_err}, 2'b00);
    app_wdf_wren = 1'b1; app_wdf_end = 1'b1;
    tick();
    app_wdf_wren = 1'b0; app_wdf_end = 1'b0;
    check("t6_overrun", protocol_err, 1);
    repeat (3) tick();
    check("t6_overrun_sticky", protocol_err, 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
